load_store_unit: RTL

Parametrised byte-serial load/store engine for the robin CPU family. It turns one word-level memory request into the 8-bit memory port sequence: byte, halfword or long, big-endian, with optional sign extension on loads. The CPU core issues requests through a req/done handshake instead of sequencing bytes in its own state machine. It sits between the CPU core and the SoC byte-wide RAM, and owns that RAM's read and write ports.

---
 rtl/load_store_unit.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-serial big-endian load/store engine for a byte-wide RAM
module load_store_unit #(
    parameter int addr_width   = 9,
    parameter int read_latency = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  signext,
    input  logic [addr_width-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           rdata,
    input  logic [7:0]            mem_data_out,
    output logic [7:0]            mem_data_in,
    output logic [addr_width-1:0] mem_raddr,
    output logic [addr_width-1:0] mem_waddr,
    output logic                  mem_write
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    localparam logic [addr_width-1:0] ADDR_ONE = {{(addr_width-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [addr_width-1:0]   raddr_q, raddr_d;
    logic [addr_width-1:0]   waddr_q, waddr_d;
    logic [7:0]              wbyte_q, wbyte_d;
    logic                    mem_write_q, mem_write_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [23:0]             acc_q, acc_d;
    logic [31:0]             sdata_q, sdata_d;
    logic [1:0]              nm1_q, nm1_d;
    logic                    signext_q, signext_d;
    logic [2:0]              iss_q, iss_d;
    logic [1:0]              rx_q, rx_d;
    logic [read_latency-1:0] vld_q, vld_d;

    logic [1:0]  req_nm1;
    logic [31:0] aligned;
    logic [31:0] word;
    logic [31:0] ext;
    logic        issue_more;
    logic        rx_last;
    logic        st_last;

    // Store data is left-aligned so byte i always leaves from the top of the shifter.
    always_comb begin
        req_nm1 = (size == 2'd0) ? 2'd0 : (size == 2'd1) ? 2'd1 : 2'd3;
        case (req_nm1)
            2'd0:    aligned = {wdata[7:0], 24'h000000};
            2'd1:    aligned = {wdata[15:0], 16'h0000};
            default: aligned = wdata;
        endcase
        word       = {acc_q, mem_data_out};
        issue_more = (iss_q <= {1'b0, nm1_q});
        rx_last    = vld_q[read_latency-1] && (rx_q == nm1_q);
        st_last    = (iss_q == {1'b0, nm1_q});
    end

    always_comb begin
        case (nm1_q)
            2'd0:    ext = signext_q ? {{24{word[7]}}, word[7:0]} : {24'h000000, word[7:0]};
            2'd1:    ext = signext_q ? {{16{word[15]}}, word[15:0]} : {16'h0000, word[15:0]};
            default: ext = word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!we)                  state_d = LOAD;
                    else if (req_nm1 != 2'd0) state_d = STORE;
                end
            end
            LOAD:    if (rx_last) state_d = IDLE;
            STORE:   if (st_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        wbyte_d     = wbyte_q;
        mem_write_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        acc_d       = acc_q;
        sdata_d     = sdata_q;
        nm1_d       = nm1_q;
        signext_d   = signext_q;
        iss_d       = iss_q;
        rx_d        = rx_q;
        vld_d       = vld_q << 1;
        case (state_q)
            IDLE: begin
                if (req) begin
                    nm1_d     = req_nm1;
                    signext_d = signext;
                    iss_d     = 3'd1;
                    busy_d    = 1'b1;
                    if (we) begin
                        waddr_d     = addr;
                        wbyte_d     = aligned[31:24];
                        sdata_d     = {aligned[23:0], 8'h00};
                        mem_write_d = 1'b1;
                        if (req_nm1 == 2'd0) begin
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end
                    end else begin
                        raddr_d  = addr;
                        rx_d     = 2'd0;
                        acc_d    = 24'h000000;
                        vld_d[0] = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Issue side runs ahead; the valid pipe marks which edges return a byte.
                if (issue_more) begin
                    raddr_d  = raddr_q + ADDR_ONE;
                    iss_d    = iss_q + 3'd1;
                    vld_d[0] = 1'b1;
                end
                if (vld_q[read_latency-1]) begin
                    acc_d = word[23:0];
                    rx_d  = rx_q + 2'd1;
                    if (rx_q == nm1_q) begin
                        rdata_d = ext;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            STORE: begin
                waddr_d     = waddr_q + ADDR_ONE;
                wbyte_d     = sdata_q[31:24];
                sdata_d     = {sdata_q[23:0], 8'h00};
                mem_write_d = 1'b1;
                iss_d       = iss_q + 3'd1;
                if (st_last) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raddr_q     <= '0;
            waddr_q     <= '0;
            wbyte_q     <= 8'h00;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= 32'h0;
            acc_q       <= 24'h0;
            sdata_q     <= 32'h0;
            nm1_q       <= 2'd0;
            signext_q   <= 1'b0;
            iss_q       <= 3'd0;
            rx_q        <= 2'd0;
            vld_q       <= '0;
        end else begin
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            wbyte_q     <= wbyte_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            acc_q       <= acc_d;
            sdata_q     <= sdata_d;
            nm1_q       <= nm1_d;
            signext_q   <= signext_d;
            iss_q       <= iss_d;
            rx_q        <= rx_d;
            vld_q       <= vld_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign mem_data_in = wbyte_q;
    assign mem_raddr   = raddr_q;
    assign mem_waddr   = waddr_q;
    assign mem_write   = mem_write_q;

endmodule
